// File: rtl/pparch_koggstone_pipe_if.sv
// Operand/result stream bundle for the pipelined Kogge-Stone adder.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface pparch_koggstone_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pparch_koggstone_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready stream handshake.
// The carry-in is folded in as a generate at bit -1, so extended index j of the
// G/P vectors stands for original bit j-1 and every carry is a group generate
// reaching down to bit -1. PIPE_MASK selects which prefix levels are registered.
module pparch_koggstone_pipe #(
   parameter int         WIDTH     = 16,
   parameter logic [7:0] PIPE_MASK = 8'b0000_0000
) (
   input logic                   clk,
   input logic                   rst_n,
   pparch_koggstone_pipe_if.slave bus
);
   localparam int          LEVELS = $clog2(WIDTH);
   localparam int          N      = WIDTH + 1;
   localparam int          SPAN   = 1 << LEVELS;
   // For power-of-two widths the top group (WIDTH..-1) is one bit wider than the
   // tree covers, so the output stage adds one final grey cell below it.
   localparam int          TOP_LO = (WIDTH >= SPAN) ? WIDTH - SPAN : 0;
   localparam logic [31:0] MASK   = 32'(PIPE_MASK);

   // Single global stall: everything holds while a result waits downstream.
   logic advance;
   assign advance      = ~(bus.out_valid & ~bus.out_ready);
   assign bus.in_ready = advance;

   // Stage 0: operand pre-processing.
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   assign b_eff = bus.sub ? ~bus.b : bus.b;
   assign c0    = bus.sub ? 1'b1 : bus.cin;

   logic             s0_valid;
   logic [N-1:0]     s0_g;
   logic [N-1:0]     s0_p;
   logic [WIDTH-1:0] s0_po;

   // Stage 0 valid bit: captures a beat exactly when one is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       s0_valid <= 1'b0;
      else if (advance) s0_valid <= bus.in_valid;
   end

   // Stage 0 data: bit -1 carries c0 as a generate with a zero propagate.
   // NOTE: datapath registers have no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (advance) begin
         s0_g  <= {bus.a & b_eff, c0};
         s0_p  <= {bus.a ^ b_eff, 1'b0};
         s0_po <= bus.a ^ b_eff;
      end
   end

   // Per-level combinational results and their (optionally used) registers.
   logic [N-1:0]     g_d  [LEVELS];
   logic [N-1:0]     p_d  [LEVELS];
   logic [WIDTH-1:0] po_d [LEVELS];
   logic             v_d  [LEVELS];
   logic [N-1:0]     g_q  [LEVELS];
   logic [N-1:0]     p_q  [LEVELS];
   logic [WIDTH-1:0] po_q [LEVELS];
   logic             v_q  [LEVELS];

   logic [N-1:0]     g_cur, p_cur, g_nxt, p_nxt;
   logic [WIDTH-1:0] po_cur;
   logic             v_cur;

   // Prefix tree walk; a masked level feeds the next level from its register.
   always_comb begin
      // NOTE: every variable gets a value before any branch, so no latch is inferred.
      g_cur  = s0_g;
      p_cur  = s0_p;
      po_cur = s0_po;
      v_cur  = s0_valid;
      g_nxt  = '0;
      p_nxt  = '0;
      for (int k = 0; k < LEVELS; k++) begin
         g_nxt = g_cur;
         p_nxt = p_cur;
         for (int j = 1 << k; j < N; j++) begin
            g_nxt[j] = g_cur[j] | (p_cur[j] & g_cur[j - (1 << k)]);
            // Black cell keeps the group propagate; a grey cell's group now
            // includes p[-1] = 0, so its propagate is zero and never read again.
            p_nxt[j] = (j >= (2 << k)) ? (p_cur[j] & p_cur[j - (1 << k)]) : 1'b0;
         end
         g_d[k]  = g_nxt;
         p_d[k]  = p_nxt;
         po_d[k] = po_cur;
         v_d[k]  = v_cur;
         if (MASK[k]) begin
            g_cur  = g_q[k];
            p_cur  = p_q[k];
            po_cur = po_q[k];
            v_cur  = v_q[k];
         end else begin
            g_cur  = g_nxt;
            p_cur  = p_nxt;
         end
      end
   end

   // Level valid bits; unmasked levels' registers are never read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LEVELS; k++) v_q[k] <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < LEVELS; k++) v_q[k] <= v_d[k];
      end
   end

   // Level datapath registers.
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int k = 0; k < LEVELS; k++) begin
            g_q[k]  <= g_d[k];
            p_q[k]  <= p_d[k];
            po_q[k] <= po_d[k];
         end
      end
   end

   // Output stage: carries into bits 0..WIDTH-1 are g_cur[WIDTH-1:0].
   logic [WIDTH-1:0] sum_d;
   logic             cout_d;
   logic             ovf_d;
   assign sum_d  = po_cur ^ g_cur[WIDTH-1:0];
   assign cout_d = g_cur[WIDTH] | (p_cur[WIDTH] & g_cur[TOP_LO]);
   assign ovf_d  = g_cur[WIDTH-1] ^ cout_d;

   // Result register: cleared on reset, held while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.sum       <= '0;
         bus.cout      <= 1'b0;
         bus.ovf       <= 1'b0;
      end else if (advance) begin
         bus.out_valid <= v_cur;
         bus.sum       <= sum_d;
         bus.cout      <= cout_d;
         bus.ovf       <= ovf_d;
      end
   end
endmodule

// File: tb/tb_pparch_koggstone_pipe.sv
// Directed bench for pparch_koggstone_pipe. Five instances share the operand and
// handshake inputs: [0] W16 mask 00 (L=2), [1] W16 mask 05 (L=4),
// [2] W16 mask 0F (L=6), [3] W16 mask 07 (L=5), [4] W13 mask 02 (L=3).
module tb_pparch_koggstone_pipe;
   localparam int NDUT = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, out_ready, cin, sub;
   logic [15:0] a, b;

   logic        in_ready_v  [NDUT];
   logic        out_valid_v [NDUT];
   logic [15:0] sum_v       [NDUT];
   logic        cout_v      [NDUT];
   logic        ovf_v       [NDUT];

   int n_checks = 0;
   int n_errs   = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < NDUT; i++) begin : g_dut
      localparam int         W = (i == 4) ? 13 : 16;
      localparam logic [7:0] M = (i == 0) ? 8'h00 : (i == 1) ? 8'h05 :
                                 (i == 2) ? 8'h0F : (i == 3) ? 8'h07 : 8'h02;
      pparch_koggstone_pipe_if #(.WIDTH(W)) bus ();
      assign bus.in_valid   = in_valid;
      assign bus.a          = a[W-1:0];
      assign bus.b          = b[W-1:0];
      assign bus.cin        = cin;
      assign bus.sub        = sub;
      assign bus.out_ready  = out_ready;
      assign in_ready_v[i]  = bus.in_ready;
      assign out_valid_v[i] = bus.out_valid;
      assign sum_v[i]       = 16'(bus.sum);
      assign cout_v[i]      = bus.cout;
      assign ovf_v[i]       = bus.ovf;
      pparch_koggstone_pipe #(.WIDTH(W), .PIPE_MASK(M)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus.slave)
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} of a w-bit add/subtract.
   function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic s);
      logic [16:0] msk, full;
      logic [15:0] xx, yy, r;
      logic        co, ov;
      msk  = (17'd1 << w) - 17'd1;
      xx   = x & msk[15:0];
      yy   = (s ? ~y : y) & msk[15:0];
      full = {1'b0, xx} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
      r    = full[15:0] & msk[15:0];
      co   = full[w];
      ov   = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
      return {ov, co, r};
   endfunction

   // Called just after a rising edge; leaves the bench just after a rising edge.
   task automatic reset_all();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One beat with out_ready=1: checks latency in rising edges and the result.
   task automatic run_one(input int sel, input logic [15:0] ai, input logic [15:0] bi,
                          input logic ci, input logic si, input logic [15:0] e_sum,
                          input logic e_cout, input logic e_ovf, input int lat, input string tag);
      int cnt;
      bit seen;
      // NOTE: inputs are driven with blocking assignments 1 ns after the edge.
      a = ai; b = bi; cin = ci; sub = si;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cnt  = 0;
      seen = 0;
      while (!seen && cnt < 20) begin
         @(posedge clk);
         #1;
         cnt++;
         in_valid = 1'b0;
         if (out_valid_v[sel]) seen = 1;
      end
      check({tag, "_lat"},  32'(cnt), 32'(lat));
      check({tag, "_sum"},  32'(sum_v[sel]), 32'(e_sum));
      check({tag, "_cout"}, 32'(cout_v[sel]), 32'(e_cout));
      check({tag, "_ovf"},  32'(ovf_v[sel]), 32'(e_ovf));
   endtask

   task automatic set_beat(input int mode, input int idx);
      case (mode)
         0: begin a = 16'(idx); b = 16'(3 * idx); cin = 1'b0; sub = 1'b0; end
         1: begin a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom); end
         default: begin a = 16'(idx * 257 + 1); b = 16'h7000 ^ 16'(idx); cin = 1'(idx); sub = 1'b0; end
      endcase
   endtask

   // Stream n beats. mode 0: a=i,b=3i with random backpressure and a 5-cycle
   // stall burst; mode 1: random operands; mode 2: timing of back-to-back beats.
   task automatic stream(input int sel, input int n, input int mode, input int lat, input string tag);
      logic [17:0] exp_q[$];
      logic [17:0] e, got, prev;
      int          w, idx, rcv, cyc, first_cyc, last_cyc, budget, extra;
      bit          prev_stall, accepted;
      w = (sel == 4) ? 13 : 16;
      idx = 0; rcv = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
      prev_stall = 0; prev = '0; budget = 4 * n + 100;
      set_beat(mode, 0);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (rcv < n && cyc < budget) begin
         @(negedge clk);
         got = {ovf_v[sel], cout_v[sel], sum_v[sel]};
         if (prev_stall)
            check({tag, "_hold"}, 32'({out_valid_v[sel], got}), 32'({1'b1, prev}));
         if (mode == 0)
            check({tag, "_in_ready"}, 32'(in_ready_v[sel]), 32'(!(out_valid_v[sel] && !out_ready)));
         prev_stall = out_valid_v[sel] && !out_ready;
         prev = got;
         if (out_valid_v[sel] && out_ready) begin
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else                   e = 'x;
            check({tag, "_result"}, 32'(got), 32'(e));
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            rcv++;
         end
         accepted = in_valid && in_ready_v[sel];
         if (accepted) exp_q.push_back(model(w, a, b, cin, sub));
         @(posedge clk);
         #1;
         cyc++;
         if (accepted) begin
            idx++;
            if (idx < n) set_beat(mode, idx);
            else         in_valid = 1'b0;
         end
         if (mode == 0) out_ready = (cyc >= 10 && cyc < 15) ? 1'b0 : ($urandom_range(0, 3) != 0);
         else           out_ready = 1'b1;
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid_v[sel]) extra++;
      end
      @(posedge clk);
      #1;
      check({tag, "_count"}, 32'(rcv), 32'(n));
      check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_extra"}, 32'(extra), 32'd0);
      if (mode == 2) begin
         check({tag, "_first"}, 32'(first_cyc), 32'(lat));
         check({tag, "_span"}, 32'(last_cyc - first_cyc), 32'(n - 1));
      end
   endtask

   initial begin
      int ov;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      #3;
      check("rst_out_valid", 32'(out_valid_v[2]), 32'd0);
      check("rst_result", 32'({ovf_v[2], cout_v[2], sum_v[2]}), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_in_ready", 32'(in_ready_v[0]), 32'd1);

      run_one(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2, "add_wrap");
      run_one(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 2, "add_ovf");
      reset_all();
      run_one(1, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4, "sub_ovf");
      run_one(1, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 4, "sub_borrow");
      reset_all();
      run_one(4, 16'h1FFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 3, "w13_wrap");

      reset_all();
      stream(2, 20, 0, 6, "bp");
      reset_all();
      stream(4, 10000, 1, 3, "w13_rand");
      reset_all();
      stream(2, 8, 2, 6, "b2b");

      // Reset with three beats in flight in the L=5 instance.
      reset_all();
      run_one(3, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 5, "mf_pre");
      in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mf_out_valid", 32'(out_valid_v[3]), 32'd0);
      check("mf_result", 32'({ovf_v[3], cout_v[3], sum_v[3]}), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("mf_in_ready", 32'(in_ready_v[3]), 32'd1);
      ov = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid_v[3]) ov++;
      end
      check("mf_no_result", 32'(ov), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/pparch_koggstone_pipe.md
Name: pparch_koggstone_pipe

Overview:
- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor.
- Generalises the fixed 16-bit combinational adder in three ways:
  - arbitrary WIDTH;
  - carry-in, add/sub mode, carry-out and signed overflow;
  - selectable pipeline registers between prefix levels, with a valid/ready stream handshake.
- Sits in the FIR datapath as the accumulate/tap-sum adder, where the clock target cannot absorb a full prefix tree.

Parameters:
- WIDTH, 16, operand/sum width in bits (>=2; power of two not required).
- PIPE_MASK, 8'b00000000, bit k=1 places a register after prefix level k (k = 0..LEVELS-1); bits >= LEVELS are ignored.
- LEVELS (localparam), $clog2(WIDTH), number of Kogge-Stone prefix levels.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add mode only).
- sub  in  1  0: A+B+cin; 1: A-B (B inverted, carry-in forced 1, cin ignored).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: one clock domain; rst_n is asynchronous and active-low.
  - All stage valid bits, out_valid, sum, cout and ovf are cleared to 0 asynchronously.
  - in_ready = 1 from the first clock after rst_n deasserts.
- Stage 0 (always registered): captures p = a ^ b', g = a & b' and c0, where b' = sub ? ~b : b and c0 = sub ? 1 : cin.
  - c0 is folded in as the bit -1 generate (g[-1] = c0, p[-1] = 0), so every carry is a group generate down to bit -1.
- Prefix levels k = 0..LEVELS-1, span 2^k:
  - Black cell where the lower operand index is still >= 0 after the shift.
  - Grey cell where the result spans bit -1; pass-through where the shifted index falls below -1.
  - A level with PIPE_MASK[k] = 1 registers its G/P vectors, the original p vector and the valid bit.
- Output stage (always registered):
  - sum = p ^ carries;
  - cout = G[WIDTH-1:-1];
  - ovf = carry[WIDTH-1] ^ cout.
- Latency: L = 2 + popcount(PIPE_MASK[LEVELS-1:0]) cycles from an accepted input to out_valid.
  - PIPE_MASK = 0 gives L = 2.
- Handshake: single global stall.
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational from out_valid and out_ready).
  - When stall is high, every pipeline register, including data, holds its value.
  - When stall is low, all stages advance. A stage with valid = 0 still advances (bubble); there is no bubble collapsing.
  - An input beat is accepted iff in_valid & in_ready.
  - An output beat is transferred iff out_valid & out_ready.
- Throughput: one beat per cycle while out_ready = 1.
- Ordering: results leave strictly in acceptance order; no beat is lost or duplicated under any out_ready pattern.
- Stall hold: sum, cout and ovf stay stable while out_valid = 1 and out_ready = 0.
- Simultaneous events: with out_valid = 1 and out_ready = 1 in the same cycle, a new input is accepted and the pipeline advances. There is no dead cycle.
- Reset mid-operation: all in-flight beats are discarded; no stale out_valid after reset.
- Operand bits (a, b, cin, sub) are don't-care when in_valid = 0. Garbage data in a bubble stage never raises out_valid.

Test Plan:
- Add, WIDTH=16, PIPE_MASK=0, out_ready=1:
  - a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, out_valid exactly 2 cycles after acceptance.
  - a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract, WIDTH=16, PIPE_MASK=8'b0101 (L=4):
  - a=0x8000, b=0x0001, sub=1, cin=1 -> sum=0x7FFF, cout=1, ovf=1, at cycle 4.
  - a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0, ovf=0 (cin ignored).
- Streaming/backpressure, PIPE_MASK=8'b1111:
  - 20 back-to-back beats with a=i, b=3*i.
  - out_ready toggles pseudo-randomly, including a 5-cycle low burst.
  - Required: results (4*i) in order, none dropped or duplicated, in_ready=0 exactly when out_valid=1 and out_ready=0, outputs stable while stalled.
- Non-power-of-two width, WIDTH=13, PIPE_MASK=8'b0010:
  - a=0x1FFF, b=0x0001, cin=1 -> sum=0x0001, cout=1.
  - Randomised check of 10k vectors against a behavioural a+b+cin / a-b model.
- Reset mid-flight, PIPE_MASK=8'b0111:
  - Accept 3 beats, assert rst_n=0 for 1 cycle before any output.
  - Required: out_valid=0, sum=0, cout=0, ovf=0 immediately (asynchronously), and no result appears afterwards.
- Simultaneous in/out:
  - out_valid=1, out_ready=1, in_valid=1 each cycle for 8 cycles -> 8 results in 8 consecutive cycles after the initial L.
